ws2812_rx: RTL

Decodes a WS2812 single-wire serial stream back into per-LED 24-bit words by measuring high-pulse width at 12 MHz. It is the receive end of the ws2812 transmitter. It is used for loopback self-test of the LED driver and for sniffing or daisy-chain capture on boards. Each LED word is emitted with a one-cycle valid strobe, a frame-done pulse fires on the reset gap, and malformed traffic is flagged.

---
 rtl/ws2812_pkg.sv | 24 ++
 rtl/ws2812_sync.sv | 34 +++
 rtl/ws2812_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants and receiver state encoding.
package ws2812_pkg;

   localparam int unsigned WORD_W = 24;

   // Transmitter timing in clk cycles: a 1 is high T_ON then low T_OFF, a 0 the reverse.
   localparam int unsigned TX_T_ON     = 10;
   localparam int unsigned TX_T_OFF    = 5;
   localparam int unsigned TX_T_PERIOD = TX_T_ON + TX_T_OFF;
   localparam int unsigned TX_T_RESET  = 800;

   localparam int unsigned RX_T_THRESH   = 8;
   localparam int unsigned RX_T_MIN_HIGH = 2;
   localparam int unsigned RX_T_MAX_HIGH = 20;
   localparam int unsigned RX_T_RESET    = 400;

   typedef enum logic [1:0] {
      StSync,
      StIdle,
      StHigh,
      StLow
   } rx_state_e;

endpackage

// File: rtl/ws2812_sync.sv
// Two-flop synchroniser for the raw serial pin followed by registered rise/fall detection.
module ws2812_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, sync_q, level_q, rise_q, fall_q;

   // rise/fall are aligned with the cycle in which level first shows the new value.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         meta_q  <= din;
         sync_q  <= meta_q;
         level_q <= sync_q;
         rise_q  <= sync_q & ~level_q;
         fall_q  <= ~sync_q & level_q;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: classifies high-pulse widths into bits, assembles 24-bit LED words and
// reports frame boundaries on the long low reset gap.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int unsigned NUM_LEDS   = 8,
   parameter int unsigned T_THRESH   = RX_T_THRESH,
   parameter int unsigned T_MIN_HIGH = RX_T_MIN_HIGH,
   parameter int unsigned T_MAX_HIGH = RX_T_MAX_HIGH,
   parameter int unsigned T_RESET    = RX_T_RESET
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              din,
   output logic [WORD_W-1:0] rgb_data,
   output logic [7:0]        led_num,
   output logic              valid,
   output logic              frame_done,
   output logic [7:0]        led_count,
   output logic              error
);

   localparam int unsigned LCNT_W = $clog2(T_RESET + 1);

   logic level, rise, fall;

   rx_state_e         state_q, state_d;
   logic [4:0]        hcnt_q, hcnt_d;
   logic [LCNT_W-1:0] lcnt_q, lcnt_d;
   logic [4:0]        bitcnt_q, bitcnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [7:0]        index_q, index_d;
   logic              ovf_q, ovf_d;
   logic [WORD_W-1:0] rgb_q, rgb_d;
   logic [7:0]        led_num_q, led_num_d;
   logic [7:0]        led_count_q, led_count_d;
   logic              valid_q, valid_d;
   logic              frame_done_q, frame_done_d;
   logic              error_q, error_d;
   logic              bit_one;
   logic [WORD_W-1:0] word_in;

   ws2812_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   assign bit_one = (hcnt_q >= 5'(T_THRESH));
   assign word_in = {shift_q[WORD_W-2:0], bit_one};

   always_comb begin
      state_d      = state_q;
      hcnt_d       = hcnt_q;
      lcnt_d       = lcnt_q;
      bitcnt_d     = bitcnt_q;
      shift_d      = shift_q;
      index_d      = index_q;
      ovf_d        = ovf_q;
      rgb_d        = rgb_q;
      led_num_d    = led_num_q;
      led_count_d  = led_count_q;
      valid_d      = 1'b0;
      frame_done_d = 1'b0;
      error_d      = 1'b0;

      unique case (state_q)
         StSync: begin
            if (level) begin
               lcnt_d = '0;
            end else if (lcnt_q == LCNT_W'(T_RESET - 1)) begin
               lcnt_d  = '0;
               state_d = StIdle;
            end else begin
               lcnt_d = lcnt_q + 1'b1;
            end
         end

         StIdle: begin
            bitcnt_d = '0;
            index_d  = '0;
            ovf_d    = 1'b0;
            shift_d  = '0;
            if (rise) begin
               hcnt_d  = 5'd1;
               state_d = StHigh;
            end
         end

         StHigh: begin
            if (fall) begin
               if (hcnt_q < 5'(T_MIN_HIGH)) begin
                  error_d = 1'b1;
                  lcnt_d  = '0;
                  state_d = StSync;
               end else begin
                  shift_d = word_in;
                  lcnt_d  = LCNT_W'(1);
                  state_d = StLow;
                  if (bitcnt_q == 5'(WORD_W - 1)) begin
                     bitcnt_d = '0;
                     // Words past capacity are dropped; flag only the first one per frame.
                     if (index_q == 8'(NUM_LEDS)) begin
                        error_d = ~ovf_q;
                        ovf_d   = 1'b1;
                     end else begin
                        rgb_d     = word_in;
                        led_num_d = index_q;
                        valid_d   = 1'b1;
                        index_d   = index_q + 8'd1;
                     end
                  end else begin
                     bitcnt_d = bitcnt_q + 5'd1;
                  end
               end
            end else if (hcnt_q == 5'(T_MAX_HIGH - 1)) begin
               error_d = 1'b1;
               lcnt_d  = '0;
               state_d = StSync;
            end else begin
               hcnt_d = hcnt_q + 5'd1;
            end
         end

         StLow: begin
            if (rise) begin
               hcnt_d  = 5'd1;
               state_d = StHigh;
            end else if (lcnt_q == LCNT_W'(T_RESET - 1)) begin
               frame_done_d = 1'b1;
               led_count_d  = index_q;
               error_d      = (bitcnt_q != 5'd0);
               state_d      = StIdle;
            end else begin
               lcnt_d = lcnt_q + 1'b1;
            end
         end

         default: state_d = StSync;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StSync;
         hcnt_q       <= '0;
         lcnt_q       <= '0;
         bitcnt_q     <= '0;
         shift_q      <= '0;
         index_q      <= '0;
         ovf_q        <= 1'b0;
         rgb_q        <= '0;
         led_num_q    <= '0;
         led_count_q  <= '0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         lcnt_q       <= lcnt_d;
         bitcnt_q     <= bitcnt_d;
         shift_q      <= shift_d;
         index_q      <= index_d;
         ovf_q        <= ovf_d;
         rgb_q        <= rgb_d;
         led_num_q    <= led_num_d;
         led_count_q  <= led_count_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         error_q      <= error_d;
      end
   end

   assign rgb_data   = rgb_q;
   assign led_num    = led_num_q;
   assign valid      = valid_q;
   assign frame_done = frame_done_q;
   assign led_count  = led_count_q;
   assign error      = error_q;

endmodule
